// File: rtl/cal_pulse_sequencer_if.sv
// cal_pulse_if
// Groups the control/config strobes coming from the AXI-lite cal-pulse register
// slave together with the pulse-train outputs and readback signals of the
// sequencer.
//
// Signals
//   start        1      launch strobe (register slave -> sequencer)
//   stop         1      abort strobe (register slave -> sequencer)
//   pulse_width  CNT_W  cal pulse high time in cycles
//   trig_delay   CNT_W  cycles from cal pulse rise to trigger
//   period       CNT_W  cycles between successive rising edges
//   repeat_cnt   REP_W  number of pulses, 0 = continuous
//   cal_pulse    1      calibration pulse to the ASIC
//   trig_out     1      one-cycle trigger per pulse
//   busy         1      sequence running
//   done         1      one-cycle strobe on normal completion
//   pulses_sent  REP_W  pulses issued in the current/last sequence
//
// Modports
//   master : register-slave side (drives strobes/config, reads status)
//   slave  : sequencer side
interface cal_pulse_if #(
    parameter int CNT_W = 32,
    parameter int REP_W = 16
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] pulse_width;
    logic [CNT_W-1:0] trig_delay;
    logic [CNT_W-1:0] period;
    logic [REP_W-1:0] repeat_cnt;
    logic             cal_pulse;
    logic             trig_out;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] pulses_sent;

    modport master (
        output start, stop, pulse_width, trig_delay, period, repeat_cnt,
        input  cal_pulse, trig_out, busy, done, pulses_sent
    );

    modport slave (
        input  start, stop, pulse_width, trig_delay, period, repeat_cnt,
        output cal_pulse, trig_out, busy, done, pulses_sent
    );
endinterface

// File: rtl/cal_pulse_sequencer.sv
// cal_pulse_sequencer
// Generates timed calibration pulse trains for the tracker ASIC cal input and a
// delayed per-pulse trigger for the readout logic. Configuration is latched on
// start, so the register slave may be rewritten while a sequence runs.
//
// Ports
//   clk      in  single clock (same as the AXI-lite slave)
//   rst      in  synchronous active-high reset
//   ctrl_io  cal_pulse_if.slave: start/stop strobes, pulse_width, trig_delay,
//            period, repeat_cnt in; cal_pulse, trig_out, busy, done,
//            pulses_sent out (all outputs registered)
//
// Build option
//   CAL_PULSE_TRIG_EN  when defined, trig_out fires trig_delay cycles after each
//                      rise and the period is stretched to exceed trig_delay.
//                      When undefined, trig_out is tied low and trig_delay is
//                      ignored.
module cal_pulse_sequencer #(
    parameter int CNT_W = 32,
    parameter int REP_W = 16
) (
    input logic        clk,
    input logic        rst,
    cal_pulse_if.slave ctrl_io
);

    // One extra bit keeps W+1 and D+1 from wrapping for all-ones inputs.
    localparam int PW = CNT_W + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    width_q, width_d;
    logic [PW-1:0]    period_q, period_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] sent_q, sent_d;
    logic             cal_q, cal_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [PW-1:0]    widthEff, periodEff, nextPhase;
    logic             lastPulse;

`ifdef CAL_PULSE_TRIG_EN
    logic [PW-1:0]    delay_q, delay_d;
    logic [PW-1:0]    delayEff;
    logic             trig_q, trig_d;
`else
    logic             unusedTrigDelay;
    assign unusedTrigDelay = ^ctrl_io.trig_delay;
`endif

    // Effective W and P from the live inputs; only used at the launch edge.
    // P must exceed W (so every pulse has a low phase) and, with triggers
    // enabled, exceed D (so each trigger lands before the next rise).
    always_comb begin
        widthEff  = (ctrl_io.pulse_width == '0) ? PW'(1) : {1'b0, ctrl_io.pulse_width};
        periodEff = {1'b0, ctrl_io.period};
        if (widthEff + PW'(1) > periodEff) periodEff = widthEff + PW'(1);
`ifdef CAL_PULSE_TRIG_EN
        delayEff = {1'b0, ctrl_io.trig_delay};
        if (delayEff + PW'(1) > periodEff) periodEff = delayEff + PW'(1);
`endif
    end

    // phase_q is the position of the current cycle inside its period; phase 0
    // is the rising-edge cycle. Outputs are computed for the next phase so the
    // registered outputs line up with the phase they belong to.
    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        period_d  = period_q;
        phase_d   = phase_q;
        reps_d    = reps_q;
        sent_d    = sent_q;
        cal_d     = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        nextPhase = phase_q + PW'(1);
        lastPulse = (reps_q != '0) && (sent_q == reps_q);
`ifdef CAL_PULSE_TRIG_EN
        delay_d   = delay_q;
        trig_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ctrl_io.start && !ctrl_io.stop) begin
                    state_d  = RUN;
                    width_d  = widthEff;
                    period_d = periodEff;
                    reps_d   = ctrl_io.repeat_cnt;
                    phase_d  = '0;
                    sent_d   = REP_W'(1);
                    cal_d    = 1'b1;
                    busy_d   = 1'b1;
`ifdef CAL_PULSE_TRIG_EN
                    delay_d  = delayEff;
                    trig_d   = (delayEff == '0);
`endif
                end
            end
            RUN: begin
                if (ctrl_io.stop) begin
                    state_d = IDLE;
                end else if (phase_q == period_q - PW'(1)) begin
                    if (lastPulse) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = '0;
                        cal_d   = 1'b1;
                        busy_d  = 1'b1;
                        // Continuous mode holds the count at all-ones.
                        if (sent_q != '1) sent_d = sent_q + REP_W'(1);
`ifdef CAL_PULSE_TRIG_EN
                        trig_d  = (delay_q == '0);
`endif
                    end
                end else begin
                    phase_d = nextPhase;
                    cal_d   = (nextPhase < width_q);
                    busy_d  = 1'b1;
`ifdef CAL_PULSE_TRIG_EN
                    trig_d  = (nextPhase == delay_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            width_q  <= '0;
            period_q <= '0;
            phase_q  <= '0;
            reps_q   <= '0;
            sent_q   <= '0;
            cal_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef CAL_PULSE_TRIG_EN
            delay_q  <= '0;
            trig_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            period_q <= period_d;
            phase_q  <= phase_d;
            reps_q   <= reps_d;
            sent_q   <= sent_d;
            cal_q    <= cal_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef CAL_PULSE_TRIG_EN
            delay_q  <= delay_d;
            trig_q   <= trig_d;
`endif
        end
    end

    assign ctrl_io.cal_pulse   = cal_q;
    assign ctrl_io.busy        = busy_q;
    assign ctrl_io.done        = done_q;
    assign ctrl_io.pulses_sent = sent_q;
`ifdef CAL_PULSE_TRIG_EN
    assign ctrl_io.trig_out    = trig_q;
`else
    assign ctrl_io.trig_out    = 1'b0;
`endif

endmodule
